// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
//
// Definitions shared by the raw image ROM reader and the image RAM writer.
//   DEF_ADDR_W   : default RAM address width (covers one 400x400 frame)
//   DEF_DATA_W   : default pixel width
//   DEF_IMG_SIZE : default pixels per frame
//   wr_state_t   : writer FSM state encoding (IDLE, WRITE, DONE)
//   pixel_t      : one pixel at the default pixel width
//   CSUM_W       : width of the running byte-sum status output
// ---------------------------------------------------------------------------
package image_pkg;

    localparam int unsigned DEF_ADDR_W   = 18;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_IMG_SIZE = 160000;
    localparam int unsigned CSUM_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

endpackage : image_pkg

// File: rtl/pixel_addr_counter.sv
// ---------------------------------------------------------------------------
// pixel_addr_counter
//
// Sequential pixel address generator for one frame.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   clear_i  : return the count to address 0
//   en_i     : advance to the next address (one accepted pixel)
//   count_o  : address of the next pixel to be written
//   last_o   : count_o is the final address of the frame (IMG_SIZE-1)
//
// The count saturates at IMG_SIZE-1 rather than wrapping, so it is safe
// even when IMG_SIZE equals 2**ADDR_W; clear_i has priority over en_i.
// ---------------------------------------------------------------------------
module pixel_addr_counter
    import image_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned IMG_SIZE = DEF_IMG_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

    logic [ADDR_W-1:0] count_q;
    logic              last;

    assign last = (count_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i && !last) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
    assign last_o  = last;

endmodule : pixel_addr_counter

// File: rtl/image_data_writer.sv
// ---------------------------------------------------------------------------
// image_data_writer
//
// Writes one frame of processed pixels, received over a valid/ready
// handshake, into the image RAM at consecutive addresses 0..IMG_SIZE-1.
// One start writes exactly one frame; done pulses for one cycle at the end.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin a frame (sampled in IDLE only)
//   in_valid   : in_data carries a pixel
//   in_data    : pixel value
//   in_ready   : a pixel is accepted this cycle when in_valid is high
//   mem_addr   : RAM write address (registered)
//   mem_data   : RAM write data (registered)
//   mem_we     : RAM write enable (registered, one cycle per pixel)
//   busy       : frame in progress (WRITE or DONE)
//   done       : one-cycle end-of-frame pulse, coincident with the last write
//   pix_count  : pixels accepted in the current or last frame
//   checksum   : 16-bit wrapping sum of accepted pixels
//
// Build option:
//   IMG_WRITE_CHECKSUM_EN : when defined, checksum accumulates the byte sum
//                           of the frame; otherwise checksum is tied to 0.
// ---------------------------------------------------------------------------
module image_data_writer
    import image_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned IMG_SIZE = DEF_IMG_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pix_count,
    output logic [CSUM_W-1:0] checksum
);

    wr_state_t         state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_we_q;
    logic [ADDR_W:0]   pix_count_q;

    logic              frame_start;
    logic              accept;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_last;

    // in_ready comes from the state register alone, so accept never forms a
    // combinational path from in_valid back to in_ready.
    assign in_ready    = (state_q == WRITE);
    assign accept      = in_valid && in_ready;
    assign frame_start = (state_q == IDLE) && start;

    pixel_addr_counter #(
        .ADDR_W   (ADDR_W),
        .IMG_SIZE (IMG_SIZE)
    ) u_addr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (frame_start),
        .en_i    (accept),
        .count_o (cnt),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= 1'b0;
            pix_count_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= WRITE;
                        pix_count_q <= '0;
                    end
                end
                WRITE: begin
                    if (in_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt;
                        mem_data_q  <= in_data;
                        pix_count_q <= pix_count_q + 1'b1;
                        // Leaving WRITE here drops in_ready, which is what
                        // stops acceptance at exactly IMG_SIZE pixels.
                        if (cnt_last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef IMG_WRITE_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (frame_start) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + CSUM_W'(in_data);
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_we    = mem_we_q;
    assign pix_count = pix_count_q;
    assign busy      = (state_q == WRITE) || (state_q == DONE);
    assign done      = (state_q == DONE);

endmodule : image_data_writer
